// File: rtl/pll_reset_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pll_reset_pkg
// Description : Shared state encodings and counter sizing for the PLL reset
//               sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package pll_reset_pkg;

    localparam int c_state_w = 3;

    localparam logic [c_state_w-1:0] c_wait_lock = 3'd0;
    localparam logic [c_state_w-1:0] c_stable    = 3'd1;
    localparam logic [c_state_w-1:0] c_hold_sys  = 3'd2;
    localparam logic [c_state_w-1:0] c_hold_cpu  = 3'd3;
    localparam logic [c_state_w-1:0] c_run       = 3'd4;

    typedef enum logic [c_state_w-1:0] {
        ST_WAIT_LOCK = c_wait_lock,
        ST_STABLE    = c_stable,
        ST_HOLD_SYS  = c_hold_sys,
        ST_HOLD_CPU  = c_hold_cpu,
        ST_RUN       = c_run
    } state_t;

    // Counter only ever holds values up to (max cycle parameter - 1).
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pll_reset_sequencer_lock_synchronizer.sv
`default_nettype none
// ============================================================================
// Module      : lock_synchronizer
// Description : SYNC_STAGES flop chain bringing an asynchronous status bit
//               into the clk domain; all stages clear on rst.
// Revision    : 1.0 - initial release
// ============================================================================
module lock_synchronizer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync
);

    logic [SYNC_STAGES-1:0] r_chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_chain[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pll_reset_sequencer
// Description : Qualifies PLL lock and sequences sys_reset then cpu_reset
//               release. Optional lock-loss counter: PLL_RESET_LOSS_COUNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pll_reset_sequencer
    import pll_reset_pkg::*;
#(
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int RESET_HOLD_CYCLES  = 16,
    parameter int CPU_RELEASE_DELAY  = 8,
    parameter int LOSS_COUNT_WIDTH   = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        pll_locked,
    output logic                        sys_reset,
    output logic                        cpu_reset,
    output logic                        ready,
    output logic [c_state_w-1:0]        state,
    output logic [LOSS_COUNT_WIDTH-1:0] lock_loss_count
);

    localparam int c_cnt_w = cnt_width(LOCK_STABLE_CYCLES, RESET_HOLD_CYCLES,
                                       CPU_RELEASE_DELAY);
    localparam logic [c_cnt_w-1:0] c_stable_last = c_cnt_w'(LOCK_STABLE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_hold_last   = c_cnt_w'(RESET_HOLD_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cpu_last    = c_cnt_w'(CPU_RELEASE_DELAY - 1);

    logic               w_locked_s;
    state_t             r_state;
    state_t             w_next_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic               w_cnt_inc;
    logic               r_sys_reset;
    logic               r_cpu_reset;
    logic               r_ready;

    lock_synchronizer #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk     (clk),
        .rst     (reset),
        .i_async (pll_locked),
        .o_sync  (w_locked_s)
    );

    // Lock loss is tested first so it beats counter completion.
    always_comb begin
        w_next_state = r_state;
        w_cnt_inc    = 1'b0;
        case (r_state)
            ST_WAIT_LOCK: begin
                if (w_locked_s) w_next_state = ST_STABLE;
            end
            ST_STABLE: begin
                if (!w_locked_s)                w_next_state = ST_WAIT_LOCK;
                else if (r_cnt == c_stable_last) w_next_state = ST_HOLD_SYS;
                else                            w_cnt_inc    = 1'b1;
            end
            ST_HOLD_SYS: begin
                if (!w_locked_s)               w_next_state = ST_WAIT_LOCK;
                else if (r_cnt == c_hold_last) w_next_state = ST_HOLD_CPU;
                else                           w_cnt_inc    = 1'b1;
            end
            ST_HOLD_CPU: begin
                if (!w_locked_s)              w_next_state = ST_WAIT_LOCK;
                else if (r_cnt == c_cpu_last) w_next_state = ST_RUN;
                else                          w_cnt_inc    = 1'b1;
            end
            ST_RUN: begin
                if (!w_locked_s) w_next_state = ST_WAIT_LOCK;
            end
            default: w_next_state = ST_WAIT_LOCK;
        endcase
    end

    // Outputs are decoded from the next state so they change with the state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_WAIT_LOCK;
            r_cnt       <= '0;
            r_sys_reset <= 1'b1;
            r_cpu_reset <= 1'b1;
            r_ready     <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_sys_reset <= (w_next_state == ST_WAIT_LOCK) ||
                           (w_next_state == ST_STABLE)    ||
                           (w_next_state == ST_HOLD_SYS);
            r_cpu_reset <= (w_next_state != ST_RUN);
            r_ready     <= (w_next_state == ST_RUN);
            if (w_next_state != r_state) begin
                r_cnt <= '0;
            end else if (w_cnt_inc) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign sys_reset = r_sys_reset;
    assign cpu_reset = r_cpu_reset;
    assign ready     = r_ready;
    assign state     = r_state;

`ifdef PLL_RESET_LOSS_COUNT_EN
    logic                        w_run_loss;
    logic [LOSS_COUNT_WIDTH-1:0] r_loss_count;

    assign w_run_loss = (r_state == ST_RUN) && !w_locked_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_loss_count <= '0;
        end else if (w_run_loss && (r_loss_count != '1)) begin
            r_loss_count <= r_loss_count + 1'b1;
        end
    end

    assign lock_loss_count = r_loss_count;
`else
    assign lock_loss_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pll_reset_sequencer
// Description : Directed self-checking bench, SYNC=2 L=4 H=2 C=3, 2-bit count.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_reset_sequencer;

    logic       clk;
    logic       reset;
    logic       pll_locked;
    logic       sys_reset;
    logic       cpu_reset;
    logic       ready;
    logic [2:0] state;
    logic [1:0] lock_loss_count;

    int n_total;
    int n_pass;

    pll_reset_sequencer #(
        .SYNC_STAGES        (2),
        .LOCK_STABLE_CYCLES (4),
        .RESET_HOLD_CYCLES  (2),
        .CPU_RELEASE_DELAY  (3),
        .LOSS_COUNT_WIDTH   (2)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .pll_locked      (pll_locked),
        .sys_reset       (sys_reset),
        .cpu_reset       (cpu_reset),
        .ready           (ready),
        .state           (state),
        .lock_loss_count (lock_loss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_loss(input int n);
`ifdef PLL_RESET_LOSS_COUNT_EN
        return (n > 3) ? 3 : n;
`else
        return 0;
`endif
    endfunction

    // Drop lock from RUN: two sync edges, then WAIT_LOCK on the third.
    task automatic loss_from_run(input int n_losses);
        pll_locked = 1'b0;
        tick();
        tick();
        check("loss_still_run", state, 4);
        check("loss_still_ready", ready, 1);
        tick();
        check("loss_state", state, 0);
        check("loss_sys", sys_reset, 1);
        check("loss_cpu", cpu_reset, 1);
        check("loss_ready", ready, 0);
        check("loss_count", lock_loss_count, exp_loss(n_losses));
    endtask

    task automatic climb_to_run();
        pll_locked = 1'b1;
        repeat (11) tick();
        check("climb_ready_e11", ready, 0);
        tick();
        check("climb_state_e12", state, 4);
        check("climb_ready_e12", ready, 1);
    endtask

    int exp_pu[1:12]  = '{0, 0, 1, 1, 1, 1, 2, 2, 3, 3, 3, 4};
    int exp_gl[1:16]  = '{0, 0, 1, 1, 1, 0, 1, 1, 1, 1, 2, 2, 3, 3, 3, 4};

    initial begin
        n_total    = 0;
        n_pass     = 0;
        reset      = 1'b1;
        pll_locked = 1'b0;
        repeat (3) tick();
        check("rst_state", state, 0);
        check("rst_sys", sys_reset, 1);
        check("rst_cpu", cpu_reset, 1);
        check("rst_ready", ready, 0);
        check("rst_count", lock_loss_count, 0);

        // Power-up
        reset      = 1'b0;
        pll_locked = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            tick();
            check($sformatf("pu_state_e%0d", e), state, exp_pu[e]);
            check($sformatf("pu_sys_e%0d", e), sys_reset, (e >= 9) ? 0 : 1);
            check($sformatf("pu_cpu_e%0d", e), cpu_reset, (e >= 12) ? 0 : 1);
            check($sformatf("pu_ready_e%0d", e), ready, (e >= 12) ? 1 : 0);
        end

        loss_from_run(1);

        // One-cycle glitch while in STABLE restarts the window
        pll_locked = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            if (e == 4) pll_locked = 1'b0;
            if (e == 5) pll_locked = 1'b1;
            tick();
            check($sformatf("gl_state_e%0d", e), state, exp_gl[e]);
            check($sformatf("gl_sys_e%0d", e), sys_reset, (e >= 13) ? 0 : 1);
            check($sformatf("gl_ready_e%0d", e), ready, (e >= 16) ? 1 : 0);
        end
        check("gl_count", lock_loss_count, exp_loss(1));

        loss_from_run(2);
        for (int k = 3; k <= 5; k++) begin
            climb_to_run();
            loss_from_run(k);
        end

        // locked_s falls on the edge where STABLE's cnt reaches 3
        pll_locked = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            if (e == 5) pll_locked = 1'b0;
            tick();
        end
        check("sim_state", state, 0);
        check("sim_sys", sys_reset, 1);

        // reset while in HOLD_CPU
        pll_locked = 1'b1;
        repeat (9) tick();
        check("hc_state", state, 3);
        check("hc_sys", sys_reset, 0);
        reset = 1'b1;
        tick();
        check("hcr_state", state, 0);
        check("hcr_sys", sys_reset, 1);
        check("hcr_cpu", cpu_reset, 1);
        check("hcr_count", lock_loss_count, 0);
        reset = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            tick();
            check($sformatf("rp_state_e%0d", e), state, exp_pu[e]);
            check($sformatf("rp_sys_e%0d", e), sys_reset, (e >= 9) ? 0 : 1);
            check($sformatf("rp_ready_e%0d", e), ready, (e >= 12) ? 1 : 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
